// File: rtl/prim_intr_pkg.sv
// rtl/prim_intr_pkg.sv - shared types and helpers for the interrupt coalescing front-end
package prim_intr_pkg;

    typedef enum logic [1:0] {
        CoalIdle  = 2'd0,
        CoalAccum = 2'd1,
        CoalFire  = 2'd2
    } coal_state_e;

    // Interrupt ID width; a single channel still gets a 1-bit ID port.
    function automatic int id_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/prim_intr_hw_coal_if.sv
// rtl/prim_intr_hw_coal_if.sv - reg2hw/hw2reg CSR bundle between reg_top and the interrupt front-end
interface prim_intr_hw_coal_if #(
    parameter int Width = 8,
    parameter int CntW  = 8,
    parameter int TmrW  = 16
);
    logic [Width-1:0] reg2hw_intr_enable_q;
    logic [Width-1:0] reg2hw_intr_test_q;
    logic             reg2hw_intr_test_qe;
    logic [Width-1:0] reg2hw_intr_state_q;
    logic [Width-1:0] reg2hw_intr_mode_q;
    logic [CntW-1:0]  reg2hw_coal_thresh_q;
    logic [TmrW-1:0]  reg2hw_coal_timeout_q;
    logic             hw2reg_intr_state_de;
    logic [Width-1:0] hw2reg_intr_state_d;

    modport master (
        output reg2hw_intr_enable_q, reg2hw_intr_test_q, reg2hw_intr_test_qe,
               reg2hw_intr_state_q, reg2hw_intr_mode_q, reg2hw_coal_thresh_q,
               reg2hw_coal_timeout_q,
        input  hw2reg_intr_state_de, hw2reg_intr_state_d
    );

    modport slave (
        input  reg2hw_intr_enable_q, reg2hw_intr_test_q, reg2hw_intr_test_qe,
               reg2hw_intr_state_q, reg2hw_intr_mode_q, reg2hw_coal_thresh_q,
               reg2hw_coal_timeout_q,
        output hw2reg_intr_state_de, hw2reg_intr_state_d
    );

endinterface

// File: rtl/prim_intr_coal_ctrl.sv
// rtl/prim_intr_coal_ctrl.sv - coalescing FSM with saturating event counter and timeout timer
module prim_intr_coal_ctrl
    import prim_intr_pkg::*;
#(
    parameter int CntW = 8,
    parameter int TmrW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            any_new,
    input  logic            pend_any,
    input  logic [CntW-1:0] thresh,
    input  logic [TmrW-1:0] timeout,
    output logic            irq_o
);

    localparam logic [1:0] StIdle  = 2'(CoalIdle);
    localparam logic [1:0] StAccum = 2'(CoalAccum);
    localparam logic [1:0] StFire  = 2'(CoalFire);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TmrW-1:0] tmr_q, tmr_d, tmr_inc;
    logic            bypass, hit_cnt, hit_tmr, irq_q;

    assign bypass  = (thresh <= CntW'(1));
    assign cnt_inc = (any_new && (cnt_q != '1)) ? cnt_q + CntW'(1) : cnt_q;
    assign tmr_inc = (tmr_q != '1) ? tmr_q + TmrW'(1) : tmr_q;
    // The count compare sees this cycle's event; the timer compare uses the elapsed count.
    assign hit_cnt = (cnt_inc >= thresh);
    assign hit_tmr = (timeout != '0) && (tmr_q >= timeout - TmrW'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        if (bypass) begin
            state_d = StIdle;
            cnt_d   = '0;
            tmr_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_new) begin
                        state_d = StAccum;
                        cnt_d   = CntW'(1);
                        tmr_d   = '0;
                    end
                end
                StAccum: begin
                    if (!pend_any && !any_new) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        tmr_d = tmr_inc;
                        if (hit_cnt || hit_tmr) begin
                            state_d = StFire;
                        end
                    end
                end
                StFire: begin
                    if (!pend_any) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        tmr_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tmr_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            irq_q   <= bypass ? pend_any : (state_d == StFire);
        end
    end

    assign irq_o = irq_q;

endmodule

// File: rtl/prim_intr_hw_coal.sv
// rtl/prim_intr_hw_coal.sv - per-channel edge/level interrupt detection with aggregate coalesced irq
module prim_intr_hw_coal
    import prim_intr_pkg::*;
#(
    parameter int Width      = 8,
    parameter bit FlopOutput = 1'b1,
    parameter int CntW       = 8,
    parameter int TmrW       = 16,
    localparam int IdW       = id_width(Width)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [Width-1:0]  event_intr_i,
    prim_intr_hw_coal_if.slave reg_if,
    output logic [Width-1:0]  intr_o,
    output logic              irq_o,
    output logic [IdW-1:0]    irq_id_o
);

    logic [Width-1:0] event_q, det, new_event, pend;
    logic [IdW-1:0]   pend_id;
    logic             any_new;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            event_q <= '0;
        end else begin
            event_q <= event_intr_i;
        end
    end

    assign det = (event_intr_i & ~event_q & reg_if.reg2hw_intr_mode_q)
               | (event_intr_i & ~reg_if.reg2hw_intr_mode_q);
    assign new_event = ({Width{reg_if.reg2hw_intr_test_qe}} & reg_if.reg2hw_intr_test_q) | det;

    assign reg_if.hw2reg_intr_state_de = |new_event;
    assign reg_if.hw2reg_intr_state_d  = new_event | reg_if.reg2hw_intr_state_q;

    assign pend    = reg_if.reg2hw_intr_state_q & reg_if.reg2hw_intr_enable_q;
    assign any_new = |(new_event & reg_if.reg2hw_intr_enable_q);

    // Scan downward so the lowest set index wins.
    always_comb begin
        pend_id = '0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (pend[i]) begin
                pend_id = IdW'(i);
            end
        end
    end

    if (FlopOutput) begin : g_flop
        logic [Width-1:0] intr_q;
        logic [IdW-1:0]   id_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                intr_q <= '0;
                id_q   <= '0;
            end else begin
                intr_q <= pend;
                id_q   <= pend_id;
            end
        end
        assign intr_o   = intr_q;
        assign irq_id_o = id_q;
    end else begin : g_comb
        assign intr_o   = pend;
        assign irq_id_o = pend_id;
    end

    prim_intr_coal_ctrl #(
        .CntW (CntW),
        .TmrW (TmrW)
    ) u_ctrl (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .any_new  (any_new),
        .pend_any (|pend),
        .thresh   (reg_if.reg2hw_coal_thresh_q),
        .timeout  (reg_if.reg2hw_coal_timeout_q),
        .irq_o    (irq_o)
    );

endmodule
